// File: rtl/cursor_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_pos_ctrl
// Brief    : Turns accepted PS/2 movement packets into a clamped cursor
//            position and button state. The shadow is committed at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_pos_ctrl #(
    parameter int H_MAX  = 640,
    parameter int V_MAX  = 480,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [8:0] pkt_dx,
    input  logic [8:0] pkt_dy,
    input  logic       pkt_ovf_x,
    input  logic       pkt_ovf_y,
    input  logic [2:0] pkt_btn,
    input  logic       frame_start,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [2:0] btn,
    output logic       upd,
    output logic       pend
);

    localparam logic [9:0] c_x_max  = 10'(H_MAX - 1);
    localparam logic [9:0] c_y_max  = 10'(V_MAX - 1);
    localparam logic [9:0] c_x_init = 10'(X_INIT);
    localparam logic [9:0] c_y_init = 10'(Y_INIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY_X = 2'd1,
        S_APPLY_Y = 2'd2
    } state_t;

    state_t      r_state;
    logic [8:0]  r_dx;
    logic [8:0]  r_dy;
    logic [2:0]  r_btn_hold;
    logic [9:0]  r_shadow_x;
    logic [9:0]  r_shadow_y;
    logic [2:0]  r_shadow_btn;
    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;
    logic [2:0]  r_btn;
    logic        r_upd;
    logic        r_dirty;
    logic        r_commit_req;

    logic [11:0] w_sum_x;
    logic [11:0] w_sum_y;
    logic [9:0]  w_new_x;
    logic [9:0]  w_new_y;
    logic        w_commit;

    // An overflowed axis saturates to the extreme delta in its sign direction.
    function automatic logic [8:0] f_eff(input logic [8:0] d, input logic ovf);
        logic [8:0] r;
        r = d;
        if (ovf) begin
            r = d[8] ? 9'h100 : 9'h0FF;
        end
        return r;
    endfunction

    function automatic logic [9:0] f_clamp(input logic [11:0] v, input logic [9:0] hi);
        logic [9:0] r;
        if (v[11]) begin
            r = 10'd0;
        end else if (v > {2'b00, hi}) begin
            r = hi;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Screen Y grows downward while PS/2 dy is positive-up, hence the subtract.
    assign w_sum_x  = {2'b00, r_shadow_x} + {{3{r_dx[8]}}, r_dx};
    assign w_sum_y  = {2'b00, r_shadow_y} - {{3{r_dy[8]}}, r_dy};
    assign w_new_x  = f_clamp(w_sum_x, c_x_max);
    assign w_new_y  = f_clamp(w_sum_y, c_y_max);
    assign w_commit = (r_state == S_IDLE) && r_commit_req;

    assign pkt_ready = (r_state == S_IDLE) && !r_commit_req && !reset;

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;
    assign btn   = r_btn;
    assign upd   = r_upd;
    assign pend  = r_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dx         <= 9'd0;
            r_dy         <= 9'd0;
            r_btn_hold   <= 3'd0;
            r_shadow_x   <= c_x_init;
            r_shadow_y   <= c_y_init;
            r_shadow_btn <= 3'd0;
            r_pos_x      <= c_x_init;
            r_pos_y      <= c_y_init;
            r_btn        <= 3'd0;
            r_upd        <= 1'b0;
            r_dirty      <= 1'b0;
            r_commit_req <= 1'b0;
        end else begin
            r_upd <= 1'b0;

            // A pulse landing on the commit cycle re-arms for the next IDLE cycle.
            if (frame_start) begin
                r_commit_req <= 1'b1;
            end else if (w_commit) begin
                r_commit_req <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_commit) begin
                        if (r_dirty) begin
                            r_pos_x <= r_shadow_x;
                            r_pos_y <= r_shadow_y;
                            r_btn   <= r_shadow_btn;
                            r_upd   <= 1'b1;
                            r_dirty <= 1'b0;
                        end
                    end else if (pkt_valid) begin
                        r_dx       <= f_eff(pkt_dx, pkt_ovf_x);
                        r_dy       <= f_eff(pkt_dy, pkt_ovf_y);
                        r_btn_hold <= pkt_btn;
                        r_state    <= S_APPLY_X;
                    end
                end
                S_APPLY_X: begin
                    r_shadow_x <= w_new_x;
                    r_state    <= S_APPLY_Y;
                end
                S_APPLY_Y: begin
                    r_shadow_y   <= w_new_y;
                    r_shadow_btn <= r_btn_hold;
                    r_dirty      <= (r_shadow_x != r_pos_x) || (w_new_y != r_pos_y) ||
                                    (r_btn_hold != r_btn);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_pos_ctrl
// Brief    : Directed scenario bench for cursor_pos_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_pos_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic       pkt_ovf_x;
    logic       pkt_ovf_y;
    logic [2:0] pkt_btn;
    logic       frame_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [2:0] btn;
    logic       upd;
    logic       pend;

    int n_cmp = 0;
    int n_bad = 0;

    cursor_pos_ctrl #(
        .H_MAX (640),
        .V_MAX (480),
        .X_INIT(320),
        .Y_INIT(240)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_dx     (pkt_dx),
        .pkt_dy     (pkt_dy),
        .pkt_ovf_x  (pkt_ovf_x),
        .pkt_ovf_y  (pkt_ovf_y),
        .pkt_btn    (pkt_btn),
        .frame_start(frame_start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .btn        (btn),
        .upd        (upd),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one packet, waits for the accept edge, then lets the FSM return to IDLE.
    task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy,
                            input logic ox, input logic oy, input logic [2:0] b);
        int n;
        n = 0;
        pkt_dx = dx; pkt_dy = dy; pkt_ovf_x = ox; pkt_ovf_y = oy; pkt_btn = b;
        pkt_valid = 1'b1;
        while (pkt_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL pkt_accept_timeout: ready=%b want 1", pkt_ready);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Pulses frame_start and checks the committed result plus the number of upd pulses.
    task automatic commit_frame(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                                input logic [2:0] eb, input int eupd);
        int nu;
        nu = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (upd === 1'b1) nu++;
        end
        n_cmp++; if (nu != eupd) begin n_bad++; $display("FAIL %s_upd_count: got %0d want %0d", tag, nu, eupd); end
        n_cmp++; if (pos_x !== ex) begin n_bad++; $display("FAIL %s_pos_x: got %0d want %0d", tag, pos_x, ex); end
        n_cmp++; if (pos_y !== ey) begin n_bad++; $display("FAIL %s_pos_y: got %0d want %0d", tag, pos_y, ey); end
        n_cmp++; if (btn !== eb) begin n_bad++; $display("FAIL %s_btn: got %b want %b", tag, btn, eb); end
        n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL %s_pend: got %b want 0", tag, pend); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_reset: got %b want 0", pkt_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", pkt_ready); end
        repeat (5) @(negedge clk);
        n_cmp++; if (pos_x !== 10'd320) begin n_bad++; $display("FAIL reset_pos_x: got %0d want 320", pos_x); end
        n_cmp++; if (pos_y !== 10'd240) begin n_bad++; $display("FAIL reset_pos_y: got %0d want 240", pos_y); end
        n_cmp++; if (btn !== 3'b000) begin n_bad++; $display("FAIL reset_btn: got %b want 000", btn); end
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL reset_upd: got %b want 0", upd); end
        n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b want 0", pend); end
    endtask

    task automatic test_basic_move();
        send_pkt(9'd10, 9'd5, 1'b0, 1'b0, 3'b001);
        n_cmp++; if (pend !== 1'b1) begin n_bad++; $display("FAIL basic_pend: got %b want 1", pend); end
        n_cmp++; if (pos_x !== 10'd320) begin n_bad++; $display("FAIL basic_pos_x_held: got %0d want 320", pos_x); end
        commit_frame("basic", 10'd330, 10'd235, 3'b001, 1);
    endtask

    task automatic test_clamp();
        send_pkt(9'd255, 9'd230, 1'b0, 1'b0, 3'b001);
        send_pkt(9'd45, 9'd0, 1'b0, 1'b0, 3'b001);
        commit_frame("setup", 10'd630, 10'd5, 3'b001, 1);
        send_pkt(9'd50, 9'd20, 1'b0, 1'b0, 3'b001);
        commit_frame("clamp", 10'd639, 10'd0, 3'b001, 1);
    endtask

    task automatic test_overflow();
        send_pkt(9'h100, 9'd0, 1'b1, 1'b0, 3'b001);
        commit_frame("ovf_x_neg", 10'd383, 10'd0, 3'b001, 1);
        send_pkt(9'd0, 9'h1F0, 1'b0, 1'b1, 3'b001);
        commit_frame("ovf_y_neg", 10'd383, 10'd256, 3'b001, 1);
        send_pkt(9'h005, 9'd0, 1'b1, 1'b0, 3'b001);
        send_pkt(9'h1F6, 9'd0, 1'b0, 1'b0, 3'b001);
        commit_frame("ovf_x_pos", 10'd628, 10'd256, 3'b001, 1);
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int na;
        int cyc;
        na = 0; cyc = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        pkt_dx = 9'd1; pkt_dy = 9'd0; pkt_ovf_x = 1'b0; pkt_ovf_y = 1'b0; pkt_btn = 3'b001;
        pkt_valid = 1'b1;
        while (na < 3 && cyc < 30) begin
            if (pkt_ready === 1'b1) begin
                acc[na] = cyc;
                na++;
            end
            @(negedge clk);
            cyc++;
        end
        pkt_valid = 1'b0;
        n_cmp++; if (na != 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", na); end
        n_cmp++; if (acc[1] - acc[0] != 3) begin n_bad++; $display("FAIL b2b_spacing_1: got %0d want 3", acc[1] - acc[0]); end
        n_cmp++; if (acc[2] - acc[1] != 3) begin n_bad++; $display("FAIL b2b_spacing_2: got %0d want 3", acc[2] - acc[1]); end
        repeat (2) @(negedge clk);
        n_cmp++; if (pos_x !== 10'd628) begin n_bad++; $display("FAIL b2b_pos_x_held: got %0d want 628", pos_x); end
        n_cmp++; if (pend !== 1'b1) begin n_bad++; $display("FAIL b2b_pend: got %b want 1", pend); end
        commit_frame("b2b", 10'd631, 10'd256, 3'b001, 1);
    endtask

    task automatic test_frame_in_apply_y();
        int n;
        int nu;
        n = 0; nu = 0;
        pkt_dx = 9'd4; pkt_dy = 9'd0; pkt_ovf_x = 1'b0; pkt_ovf_y = 1'b0; pkt_btn = 3'b001;
        pkt_valid = 1'b1;
        while (pkt_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL ay_accept_timeout: ready=%b want 1", pkt_ready); end
        @(negedge clk);
        pkt_valid = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL ay_ready_blocked: got %b want 0", pkt_ready); end
        n_cmp++; if (pend !== 1'b1) begin n_bad++; $display("FAIL ay_pend: got %b want 1", pend); end
        // frame_start stays high across the commit edge to re-arm the request
        @(negedge clk);
        frame_start = 1'b0;
        n_cmp++; if (upd !== 1'b1) begin n_bad++; $display("FAIL ay_upd: got %b want 1", upd); end
        n_cmp++; if (pos_x !== 10'd635) begin n_bad++; $display("FAIL ay_pos_x: got %0d want 635", pos_x); end
        n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL ay_rearm_ready: got %b want 0", pkt_ready); end
        @(negedge clk);
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL ay_empty_commit_upd: got %b want 0", upd); end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL ay_ready_restored: got %b want 1", pkt_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (upd === 1'b1) nu++;
        end
        n_cmp++; if (nu != 0) begin n_bad++; $display("FAIL ay_extra_upd: got %0d want 0", nu); end
        n_cmp++; if (pos_x !== 10'd635) begin n_bad++; $display("FAIL ay_pos_x_final: got %0d want 635", pos_x); end
    endtask

    task automatic test_reset_mid_packet();
        int n;
        int nu;
        n = 0; nu = 0;
        pkt_dx = 9'd100; pkt_dy = 9'd0; pkt_ovf_x = 1'b0; pkt_ovf_y = 1'b0; pkt_btn = 3'b010;
        pkt_valid = 1'b1;
        frame_start = 1'b1;
        while (pkt_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL rst_accept_timeout: ready=%b want 1", pkt_ready); end
        @(negedge clk);
        pkt_valid = 1'b0;
        frame_start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", pkt_ready); end
        n_cmp++; if (pos_x !== 10'd320) begin n_bad++; $display("FAIL rst_pos_x: got %0d want 320", pos_x); end
        n_cmp++; if (pos_y !== 10'd240) begin n_bad++; $display("FAIL rst_pos_y: got %0d want 240", pos_y); end
        n_cmp++; if (btn !== 3'b000) begin n_bad++; $display("FAIL rst_btn: got %b want 000", btn); end
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL rst_upd: got %b want 0", upd); end
        n_cmp++; if (pend !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b want 0", pend); end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (upd === 1'b1) nu++;
        end
        n_cmp++; if (nu != 0) begin n_bad++; $display("FAIL rst_stray_upd: got %0d want 0", nu); end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", pkt_ready); end
        commit_frame("rst_empty", 10'd320, 10'd240, 3'b000, 0);
        send_pkt(9'h1FB, 9'd3, 1'b0, 1'b0, 3'b100);
        commit_frame("rst_after", 10'd315, 10'd237, 3'b100, 1);
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; pkt_dx = 9'd0; pkt_dy = 9'd0;
        pkt_ovf_x = 1'b0; pkt_ovf_y = 1'b0; pkt_btn = 3'b000; frame_start = 1'b0;
        test_reset();
        test_basic_move();
        test_clamp();
        test_overflow();
        test_back_to_back();
        test_frame_in_apply_y();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
